board_io_ctrl: RTL and testbench

//  Board-level front end for Z16-class cores: replaces a divided fabric clock with a single-clock

---
 rtl/board_io_pkg.sv | 16 +
 rtl/board_io_ctrl_btn_debounce.sv | 59 +++++
 rtl/board_io_ctrl.sv | 129 ++++++++++++
 tb/tb_board_io_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/board_io_pkg.sv
// Shared mode encodings and sizing helper for the board I/O front end.
package board_io_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_RUN_SLOW = 2'b00;
  localparam logic [MODE_W-1:0] MODE_RUN_FAST = 2'b01;
  localparam logic [MODE_W-1:0] MODE_STEP     = 2'b10;
  localparam logic [MODE_W-1:0] MODE_HALT     = 2'b11;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/board_io_ctrl_btn_debounce.sv
// One button channel: polarity fix, 2-flop sync, stability counter, level and rise pulse.
module btn_debounce
  import board_io_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYC = 270_000,
  parameter bit          ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pad,
  output logic o_level,
  output logic o_rise
);

  localparam int unsigned     CW       = cnt_width(DEBOUNCE_CYC);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          pressed;
  logic [1:0]    sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          level_q, level_d;
  logic          rise_q, rise_d;

  assign pressed = ACTIVE_LOW ? ~i_pad : i_pad;

  always_comb begin
    sync_d  = {sync_q[0], pressed};
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d = ~level_q;
      rise_d  = ~level_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign o_level = level_q;
  assign o_rise  = rise_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board front end: clock-enable generator with run modes, debounced buttons,
// stretched core reset and registered LED pads, all on one clock.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int unsigned TICK_DIV       = 2_700_000,
  parameter int unsigned N_BTN          = 2,
  parameter int unsigned DEBOUNCE_CYC   = 270_000,
  parameter int unsigned STEP_BTN       = 0,
  parameter int unsigned RST_HOLD       = 16,
  parameter int unsigned N_LED          = 6,
  parameter bit          BTN_ACTIVE_LOW = 1'b1,
  parameter bit          LED_ACTIVE_LOW = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [MODE_W-1:0] i_mode,
  input  logic [N_BTN-1:0]  i_btn,
  input  logic [N_LED-1:0]  i_led,
  output logic              o_ce,
  output logic              o_core_rst,
  output logic [N_BTN-1:0]  o_btn_level,
  output logic [N_BTN-1:0]  o_btn_rise,
  output logic [N_LED-1:0]  o_led
);

  localparam int unsigned    TW        = cnt_width(TICK_DIV);
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam int unsigned    HW        = cnt_width(RST_HOLD);
  localparam logic [HW-1:0]  HOLD_LAST = HW'(RST_HOLD - 1);
  localparam logic [N_LED-1:0] LED_OFF = LED_ACTIVE_LOW ? {N_LED{1'b1}} : {N_LED{1'b0}};

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic              core_rst_q, core_rst_d;
  logic [MODE_W-1:0] mode_s0_q, mode_s0_d;
  logic [MODE_W-1:0] mode_s1_q, mode_s1_d;
  logic [MODE_W-1:0] mode_prev_q, mode_prev_d;
  logic              mode_changed;
  logic [TW-1:0]     tick_cnt_q, tick_cnt_d;
  logic              ce_q, ce_d;
  logic [N_LED-1:0]  led_q, led_d;

  // Core reset stays high until the synced release has been seen for RST_HOLD cycles.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
    hold_cnt_d = hold_cnt_q;
    core_rst_d = core_rst_q;
    if (rst_sync_q[1] && core_rst_q) begin
      if (hold_cnt_q == HOLD_LAST) begin
        core_rst_d = 1'b0;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  assign mode_changed = (mode_s1_q != mode_prev_q);

  always_comb begin
    mode_s0_d   = i_mode;
    mode_s1_d   = mode_s0_q;
    mode_prev_d = mode_s1_q;
    tick_cnt_d  = '0;
    ce_d        = 1'b0;
    // A mode change suppresses o_ce and restarts the divider in the same cycle.
    if (!core_rst_q && !mode_changed) begin
      case (mode_s1_q)
        MODE_RUN_SLOW: begin
          ce_d       = (tick_cnt_q == TICK_LAST);
          tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
        end
        MODE_RUN_FAST: ce_d = 1'b1;
        MODE_STEP:     ce_d = o_btn_rise[STEP_BTN];
        default:       ce_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    if (core_rst_q) begin
      led_d = LED_OFF;
    end else begin
      led_d = LED_ACTIVE_LOW ? ~i_led : i_led;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      rst_sync_q  <= '0;
      hold_cnt_q  <= '0;
      core_rst_q  <= 1'b1;
      mode_s0_q   <= '0;
      mode_s1_q   <= '0;
      mode_prev_q <= '0;
      tick_cnt_q  <= '0;
      ce_q        <= 1'b0;
      led_q       <= LED_OFF;
    end else begin
      rst_sync_q  <= rst_sync_d;
      hold_cnt_q  <= hold_cnt_d;
      core_rst_q  <= core_rst_d;
      mode_s0_q   <= mode_s0_d;
      mode_s1_q   <= mode_s1_d;
      mode_prev_q <= mode_prev_d;
      tick_cnt_q  <= tick_cnt_d;
      ce_q        <= ce_d;
      led_q       <= led_d;
    end
  end

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .ACTIVE_LOW   (BTN_ACTIVE_LOW)
    ) u_db (
      .clk     (i_clk),
      .rst_n   (i_rst),
      .i_pad   (i_btn[g]),
      .o_level (o_btn_level[g]),
      .o_rise  (o_btn_rise[g])
    );
  end

  assign o_ce       = ce_q;
  assign o_core_rst = core_rst_q;
  assign o_led      = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Self-checking bench for board_io_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a cycle-count based behavioural model.
module tb_board_io_ctrl;

  localparam int unsigned TICK_DIV = 4;
  localparam int unsigned N_BTN    = 2;
  localparam int unsigned DEB      = 8;
  localparam int unsigned STEP_BTN = 0;
  localparam int unsigned RST_HOLD = 4;
  localparam int unsigned N_LED    = 6;

  logic             clk   = 1'b0;
  logic             i_rst = 1'b1;
  logic [1:0]       i_mode = 2'b00;
  logic [N_BTN-1:0] i_btn = '1;
  logic [N_LED-1:0] i_led = '0;
  logic             o_ce, o_core_rst;
  logic [N_BTN-1:0] o_btn_level, o_btn_rise;
  logic [N_LED-1:0] o_led;

  int n_tests = 0;
  int n_fail  = 0;

  board_io_ctrl #(
    .TICK_DIV       (TICK_DIV),
    .N_BTN          (N_BTN),
    .DEBOUNCE_CYC   (DEB),
    .STEP_BTN       (STEP_BTN),
    .RST_HOLD       (RST_HOLD),
    .N_LED          (N_LED),
    .BTN_ACTIVE_LOW (1'b1),
    .LED_ACTIVE_LOW (1'b1)
  ) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_mode      (i_mode),
    .i_btn       (i_btn),
    .i_led       (i_led),
    .o_ce        (o_ce),
    .o_core_rst  (o_core_rst),
    .o_btn_level (o_btn_level),
    .o_btn_rise  (o_btn_rise),
    .o_led       (o_led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural model: edges since reset release, delayed input histories,
  // run-length of disagreement per button, cycles since the slow divider last restarted.
  int               m_edges;
  logic             m_cr;
  logic [1:0]       m_mh0, m_mh1, m_mprev;
  logic [N_BTN-1:0] m_ph0, m_ph1, m_lvl, m_rise;
  int               m_run [N_BTN];
  int               m_since;
  logic             m_ce;
  logic [N_LED-1:0] m_led;

  assign m_cr = (m_edges < int'(RST_HOLD) + 2);

  always @(posedge clk or negedge i_rst) begin
    if (!i_rst) begin
      m_edges <= 0;
      m_mh0   <= '0;
      m_mh1   <= '0;
      m_mprev <= '0;
      m_ph0   <= '0;
      m_ph1   <= '0;
      m_lvl   <= '0;
      m_rise  <= '0;
      for (int c = 0; c < int'(N_BTN); c++) m_run[c] <= 0;
      m_since <= 0;
      m_ce    <= 1'b0;
      m_led   <= '1;
    end else begin
      m_edges <= (m_edges < 1000) ? m_edges + 1 : m_edges;
      m_mh0   <= i_mode;
      m_mh1   <= m_mh0;
      m_mprev <= m_mh1;
      m_ph0   <= ~i_btn;
      m_ph1   <= m_ph0;
      for (int c = 0; c < int'(N_BTN); c++) begin
        if (m_ph1[c] != m_lvl[c]) begin
          if (m_run[c] + 1 == int'(DEB)) begin
            m_lvl[c]  <= ~m_lvl[c];
            m_rise[c] <= ~m_lvl[c];
            m_run[c]  <= 0;
          end else begin
            m_run[c]  <= m_run[c] + 1;
            m_rise[c] <= 1'b0;
          end
        end else begin
          m_run[c]  <= 0;
          m_rise[c] <= 1'b0;
        end
      end
      if (m_cr || (m_mh1 != m_mprev) || (m_mh1 != 2'b00)) m_since <= 0;
      else m_since <= m_since + 1;
      m_ce <= !m_cr && (m_mh1 == m_mprev) &&
              ((m_mh1 == 2'b00 && (m_since % int'(TICK_DIV)) == int'(TICK_DIV) - 1) ||
               (m_mh1 == 2'b01) ||
               (m_mh1 == 2'b10 && m_rise[STEP_BTN]));
      m_led <= m_cr ? '1 : ~i_led;
    end
  end

  always @(negedge clk) begin
    chk("model_ce",       int'(o_ce),        int'(m_ce));
    chk("model_core_rst", int'(o_core_rst),  int'(m_cr));
    chk("model_level",    int'(o_btn_level), int'(m_lvl));
    chk("model_rise",     int'(o_btn_rise),  int'(m_rise));
    chk("model_led",      int'(o_led),       int'(m_led));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  int         k;
  int         cnt;
  int         cnt2;
  logic       seen;
  logic       prev_rise;
  logic [11:0] mask;
  int         rem [N_BTN];

  initial begin
    #1 i_rst = 1'b0;
    repeat (3) tick();
    chk("rst_led",      int'(o_led), 'h3f);
    chk("rst_core_rst", int'(o_core_rst), 1);
    chk("rst_ce",       int'(o_ce), 0);

    // Reset release and hold length
    i_rst = 1'b1;
    k = 0; seen = 1'b0;
    while (o_core_rst && k < 50) begin
      tick(); k++;
      if (o_ce) seen = 1'b1;
    end
    chk("rst_hold_len", k, 6);
    chk("ce_during_rst", int'(seen), 0);

    // RUN_SLOW pulses, HALT at cycle 10
    mask = '0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      mask[i-1] = o_ce;
      if (i == 10) i_mode = 2'b11;
    end
    chk("slow_pulse_mask", int'(mask), 'h888);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin tick(); if (o_ce) cnt++; end
    chk("halt_no_ce", cnt, 0);
    i_mode = 2'b01;
    repeat (3) tick();
    cnt = 0;
    for (int i = 0; i < 8; i++) begin tick(); if (o_ce) cnt++; end
    chk("fast_every_cycle", cnt, 8);

    // Button glitch and clean press/release
    i_mode = 2'b11;
    repeat (4) tick();
    i_btn[1] = 1'b0;
    repeat (5) tick();
    i_btn[1] = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (o_btn_level[1] || o_btn_rise[1]) seen = 1'b1; end
    chk("glitch_ignored", int'(seen), 0);
    i_btn[1] = 1'b0;
    k = 0;
    while (!o_btn_rise[1] && k < 40) begin tick(); k++; end
    chk("press_latency", k, 10);
    chk("press_level", int'(o_btn_level[1]), 1);
    tick();
    chk("rise_one_cycle", int'(o_btn_rise[1]), 0);
    repeat (12) tick();
    i_btn[1] = 1'b1;
    k = 0; seen = 1'b0;
    while (o_btn_level[1] && k < 40) begin tick(); k++; if (o_btn_rise[1]) seen = 1'b1; end
    chk("release_latency", k, 10);
    chk("release_no_rise", int'(seen), 0);

    // STEP mode: three presses of btn0
    i_mode = 2'b10;
    repeat (5) tick();
    cnt = 0; cnt2 = 0; prev_rise = 1'b0;
    for (int p = 0; p < 3; p++) begin
      for (int h = 0; h < 2; h++) begin
        i_btn[0] = (h == 1);
        for (int i = 0; i < 14; i++) begin
          tick();
          if (o_ce) begin cnt++; if (prev_rise) cnt2++; end
          prev_rise = o_btn_rise[0];
        end
      end
    end
    chk("step_pulses", cnt, 3);
    chk("step_after_rise", cnt2, 3);

    // LED polarity, then reset mid-debounce and mid-tick
    i_led = 6'b000101;
    tick();
    chk("led_polarity", int'(o_led), 'h3a);
    i_mode = 2'b00;
    repeat (8) tick();
    i_btn[1] = 1'b0;
    repeat (5) tick();
    i_rst = 1'b0;
    #1;
    chk("midrst_ce",       int'(o_ce), 0);
    chk("midrst_core_rst", int'(o_core_rst), 1);
    chk("midrst_level",    int'(o_btn_level), 0);
    chk("midrst_rise",     int'(o_btn_rise), 0);
    chk("midrst_led",      int'(o_led), 'h3f);
    i_btn = '1;
    repeat (2) tick();
    i_rst = 1'b1;
    k = 0;
    while (o_core_rst && k < 50) begin tick(); k++; end
    chk("rerst_hold_len", k, 6);
    k = 0;
    while (!o_ce && k < 50) begin tick(); k++; end
    chk("rerst_first_ce", k, 4);

    // Randomized traffic, checked by the per-cycle compare process
    for (int c = 0; c < int'(N_BTN); c++) rem[c] = $urandom_range(1, 20);
    for (int i = 0; i < 4000; i++) begin
      tick();
      i_led = N_LED'($urandom);
      if ($urandom_range(0, 39) == 0) i_mode = 2'($urandom);
      for (int c = 0; c < int'(N_BTN); c++) begin
        rem[c]--;
        if (rem[c] <= 0) begin
          i_btn[c] = ~i_btn[c];
          rem[c] = $urandom_range(1, 20);
        end
      end
      if ($urandom_range(0, 599) == 0) begin
        i_rst = 1'b0;
        repeat ($urandom_range(1, 3)) tick();
        i_rst = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
